// File: rtl/idwt_pkg.sv
// idwt_pkg: shared types and constants for the streaming LeGall 5/3 inverse DWT.
// Build option: define IDWT_SAT_EN to saturate outputs instead of wrapping them.
package idwt_pkg;

    // Output phase of the reconstructor
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for a coefficient pair
        ST_ODD  = 2'd1,  // presenting o[n-1]
        ST_EVEN = 2'd2,  // presenting e[n]
        ST_TAIL = 2'd3   // presenting o[N-1] with mirrored e[N]
    } idwt_state_e;

    // Extra headroom bits carried through the lifting arithmetic
    localparam int EXT_W = 2;

    // Lifting rounding: e = L - ((Hp + H + RND_E) >>> SH_E); o = H + ((e + e1) >>> SH_O)
    localparam int RND_E = 2;
    localparam int SH_E  = 2;
    localparam int SH_O  = 1;

endpackage

// File: rtl/idwt_clip.sv
// idwt_clip: reduces a SIZE+EXT_W wide signed lifting result to SIZE bits.
// Build option: IDWT_SAT_EN selects saturation; otherwise two's-complement wrap.
module idwt_clip
    import idwt_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic signed [SIZE+EXT_W-1:0] din,
    output logic signed [SIZE-1:0]       dout
);

`ifdef IDWT_SAT_EN
    localparam logic signed [SIZE-1:0] MAX_V = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic signed [SIZE-1:0] MIN_V = {1'b1, {(SIZE-1){1'b0}}};

    // In range only when every bit above the result's sign bit copies it
    logic [EXT_W:0] top_bits;
    assign top_bits = din[SIZE+EXT_W-1:SIZE-1];

    // Clamp to the signed SIZE range
    always_comb begin
        if ((&top_bits) || !(|top_bits)) dout = din[SIZE-1:0];
        else if (din[SIZE+EXT_W-1])      dout = MIN_V;
        else                             dout = MAX_V;
    end
`else
    // Headroom bits are simply dropped in wrap mode
    logic clip_unused;
    assign clip_unused = ^din[SIZE+EXT_W-1:SIZE];
    assign dout        = din[SIZE-1:0];
`endif

endmodule

// File: rtl/idwt_stream.sv
// idwt_stream: streaming one-level inverse LeGall 5/3 DWT. Accepts (L,H) pairs
// and emits e0,o0,e1,o1,... with symmetric extension at both frame ends.
// Build option: IDWT_SAT_EN saturates each output (see idwt_clip).
module idwt_stream
    import idwt_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [SIZE-1:0] in_l,
    input  logic signed [SIZE-1:0] in_h,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [SIZE-1:0] out_x,
    output logic                   out_last
);

    localparam int W = SIZE + EXT_W;
    typedef logic signed [W-1:0] wide_t;

    idwt_state_e state, state_nxt;

    // h_cur/e_cur hold H[n]/e[n] of the newest pair. o[n-1] is formed at the
    // moment pair n is accepted, while these still hold the n-1 values, so the
    // "previous" slot never needs its own register.
    wide_t h_cur, e_cur;
    logic  first_q, last_q;

    wide_t l_w, h_w, hp_w, e_new, o_val, x_wide;
    logic signed [SIZE-1:0] x_clip;
    logic accept, adv, last_nxt;

    assign in_ready = (state == ST_IDLE) | ((state == ST_EVEN) & out_ready & ~last_q);
    assign accept   = in_valid & in_ready;
    // Output register advances on an accept in IDLE, or a handshake elsewhere
    assign adv      = (state == ST_IDLE) ? accept : out_ready;

    // Lifting datapath for the incoming pair
    always_comb begin
        l_w   = W'(in_l);
        h_w   = W'(in_h);
        hp_w  = first_q ? h_w : h_cur;   // H[-1] = H[0] at frame start
        e_new = l_w - ((hp_w + h_w + wide_t'(RND_E)) >>> SH_E);
        o_val = h_cur + ((e_cur + e_new) >>> SH_O);
    end

    // Next state and the value the output register loads on advance
    always_comb begin
        state_nxt = state;
        x_wide    = e_cur;
        last_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = first_q ? ST_EVEN : ST_ODD;
                    x_wide    = first_q ? e_new : o_val;
                end
            end
            ST_ODD: begin
                if (out_ready) begin
                    state_nxt = ST_EVEN;
                    x_wide    = e_cur;
                end
            end
            ST_EVEN: begin
                if (out_ready) begin
                    if (last_q) begin
                        // e[N] mirrors e[N-1], so o[N-1] = H + e
                        state_nxt = ST_TAIL;
                        x_wide    = h_cur + e_cur;
                        last_nxt  = 1'b1;
                    end else if (accept) begin
                        state_nxt = first_q ? ST_EVEN : ST_ODD;
                        x_wide    = first_q ? e_new : o_val;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_TAIL: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    idwt_clip #(.SIZE(SIZE)) u_clip (
        .din  (x_wide),
        .dout (x_clip)
    );

    // State and registered output beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (adv) begin
                out_valid <= (state_nxt != ST_IDLE);
                out_last  <= last_nxt;
                if (state_nxt != ST_IDLE) out_x <= x_clip;
            end
        end
    end

    // Coefficient registers and frame-boundary flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cur   <= '0;
            e_cur   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (accept) begin
            h_cur   <= h_w;
            e_cur   <= e_new;
            first_q <= 1'b0;
            last_q  <= in_last;
        end else if ((state == ST_TAIL) && out_ready) begin
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idwt_stream.sv
// tb_idwt_stream: table vectors, hand-written corner sequences and random
// frames checked against a lifting reference model.
`timescale 1ns/1ps
module tb_idwt_stream;

    localparam int SIZE = 32;
    localparam longint MAXL = 64'sd2147483647;
    localparam longint MINL = -64'sd2147483648;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_last;
    logic signed [SIZE-1:0] in_l = '0, in_h = '0, out_x;

    logic v8 = 1'b0, last8 = 1'b0, ordy8 = 1'b1;
    logic r8, ov8, ol8;
    logic signed [7:0] l8 = '0, h8 = '0, x8;

    always #5 clk = ~clk;

    idwt_stream #(.SIZE(SIZE)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_l(in_l), .in_h(in_h), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_last(out_last)
    );

    idwt_stream #(.SIZE(8)) dut8 (
        .clk(clk), .resetn(resetn),
        .in_valid(v8), .in_ready(r8),
        .in_l(l8), .in_h(h8), .in_last(last8),
        .out_valid(ov8), .out_ready(ordy8),
        .out_x(x8), .out_last(ol8)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // frame under test and collected / expected samples
    int fn;
    int fl[16], fh[16];
    int got_x[$];
    bit got_l[$];
    int ex_q[$];
    bit el_q[$];
    bit rec_en = 0, rec_ir = 0, abort = 0;
    bit ir_q[$];
    int ready_mode = 0;
    int stall_cnt = 0;

    // reference: arithmetic straight from the lifting equations
    function automatic int reduce(input longint v);
`ifdef IDWT_SAT_EN
        if (v > MAXL) return int'(MAXL);
        if (v < MINL) return int'(MINL);
        return int'(v);
`else
        return int'(v);
`endif
    endfunction

    task automatic model();
        longint e[16];
        longint hp, en1;
        ex_q.delete();
        el_q.delete();
        for (int n = 0; n < fn; n++) begin
            hp   = (n == 0) ? longint'(fh[0]) : longint'(fh[n-1]);
            e[n] = longint'(fl[n]) - ((hp + longint'(fh[n]) + 2) >>> 2);
        end
        for (int n = 0; n < fn; n++) begin
            en1 = (n == fn-1) ? e[n] : e[n+1];
            ex_q.push_back(reduce(e[n]));
            el_q.push_back(1'b0);
            ex_q.push_back(reduce(longint'(fh[n]) + ((e[n] + en1) >>> 1)));
            el_q.push_back(n == fn-1);
        end
    endtask

    // sink: collect beats, check stall stability
    logic stall_prev = 1'b0;
    logic signed [SIZE-1:0] x_prev = '0;
    logic l_prev = 1'b0;
    always @(negedge clk) begin
        if (!resetn) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_x", out_x, x_prev);
                check("hold_last", out_last, l_prev);
                check("hold_valid", out_valid, 1);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                got_x.push_back(out_x);
                got_l.push_back(out_last);
            end
            if (rec_ir) ir_q.push_back(in_ready);
            stall_prev <= out_valid && !out_ready;
            x_prev     <= out_x;
            l_prev     <= out_last;
        end
    end

    // downstream ready pattern
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(3) != 0);
            default: begin
                if (out_valid && got_x.size() == 1 && stall_cnt < 3) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    // enter at posedge+1; returns at posedge+1 after the last accept
    task automatic send_frame(input int gap_max);
        int budget;
        bit done;
        for (int i = 0; i < fn; i++) begin
            budget = 0;
            done = 0;
            repeat ($urandom_range(gap_max)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_l = fl[i];
            in_h = fh[i];
            in_last = (i == fn-1);
            while (!done) begin
                @(negedge clk);
                if (abort) begin in_valid = 1'b0; return; end
                done = in_ready;
                @(posedge clk); #1;
                if (!done) begin
                    budget++;
                    if (budget > 500) begin
                        total++; bad++;
                        $display("FAIL accept_timeout: pair %0d still pending, want accepted", i);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
            if (i == 0 && rec_en) rec_ir = 1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_samples(input int n);
        int k;
        k = 0;
        while (got_x.size() < n && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        if (got_x.size() < n) begin
            total++; bad++;
            $display("FAIL sample_timeout: got %0d samples, want %0d", got_x.size(), n);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_count"}, got_x.size(), ex_q.size());
        for (int i = 0; i < ex_q.size() && i < got_x.size(); i++) begin
            check({tag, "_x"}, got_x[i], ex_q[i]);
            check({tag, "_last"}, got_l[i], el_q[i]);
        end
        got_x.delete();
        got_l.delete();
    endtask

    typedef struct packed {
        logic [3:0]        n;
        logic [3:0][31:0]  l;
        logic [3:0][31:0]  h;
        logic [7:0][31:0]  x;
        logic [7:0]        lst;
    } vec_t;
    vec_t tv[4];

    bit exp_ir[9];

    initial begin
        // table: hand-computed lifting results
        tv[0] = '0; tv[0].n = 1; tv[0].l[0] = 10; tv[0].h[0] = 4;
        tv[0].x[0] = 8; tv[0].x[1] = 12; tv[0].lst = 8'b0000_0010;
        tv[1] = '0; tv[1].n = 2; tv[1].l[0] = 10; tv[1].h[0] = 4;
        tv[1].l[1] = 20; tv[1].h[1] = -2;
        tv[1].x[0] = 8; tv[1].x[1] = 17; tv[1].x[2] = 19; tv[1].x[3] = 17;
        tv[1].lst = 8'b0000_1000;
        tv[2] = '0; tv[2].n = 1; tv[2].l[0] = 0; tv[2].h[0] = -3;
        tv[2].x[0] = 1; tv[2].x[1] = -2; tv[2].lst = 8'b0000_0010;
        tv[3] = '0; tv[3].n = 3;
        tv[3].l[0] = 0; tv[3].h[0] = 0; tv[3].l[1] = 8; tv[3].h[1] = 4;
        tv[3].l[2] = -8; tv[3].h[2] = -4;
        tv[3].x[0] = 0; tv[3].x[1] = 3; tv[3].x[2] = 7; tv[3].x[3] = 3;
        tv[3].x[4] = -8; tv[3].x[5] = -12; tv[3].lst = 8'b0010_0000;
        exp_ir = '{1, 0, 1, 0, 1, 0, 0, 0, 1};

        // reset state
        #1 resetn = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // SIZE=8 overflow corner: e0=63, o0=190 reduced
        v8 = 1'b1; l8 = 8'sd127; h8 = 8'sd127; last8 = 1'b1;
        @(negedge clk);
        check("s8_in_ready", r8, 1);
        @(posedge clk); #1;
        v8 = 1'b0;
        @(negedge clk);
        check("s8_latency_valid", ov8, 1);
        check("s8_e0", x8, 63);
        check("s8_e0_last", ol8, 0);
        @(negedge clk);
`ifdef IDWT_SAT_EN
        check("s8_o0", x8, 127);
`else
        check("s8_o0", x8, -66);
`endif
        check("s8_o0_last", ol8, 1);
        @(negedge clk);
        check("s8_idle", ov8, 0);
        @(posedge clk); #1;

        // table vectors, out_ready held high
        for (int t = 0; t < 4; t++) begin
            fn = int'(tv[t].n);
            for (int j = 0; j < fn; j++) begin
                fl[j] = int'(tv[t].l[j]);
                fh[j] = int'(tv[t].h[j]);
            end
            send_frame(0);
            wait_samples(2 * fn);
            check("tab_count", got_x.size(), 2 * fn);
            for (int j = 0; j < 2 * fn && j < got_x.size(); j++) begin
                check("tab_x", got_x[j], int'(tv[t].x[j]));
                check("tab_last", got_l[j], tv[t].lst[j]);
            end
            got_x.delete();
            got_l.delete();
            @(posedge clk); #1;
        end

        // in_ready cadence on a 4-pair frame with no stalls
        fn = 4;
        for (int j = 0; j < 4; j++) begin
            fl[j] = $urandom_range(200) - 100;
            fh[j] = $urandom_range(200) - 100;
        end
        model();
        rec_en = 1; ir_q.delete();
        send_frame(0);
        wait_samples(8);
        @(negedge clk); #1;
        rec_ir = 0; rec_en = 0;
        check("ir_count", ir_q.size() >= 9, 1);
        for (int j = 0; j < 9 && j < ir_q.size(); j++) check("ir_toggle", ir_q[j], exp_ir[j]);
        compare_model("cadence");
        @(posedge clk); #1;

        // backpressure: 3 stall cycles while o0 is presented
        stall_cnt = 0;
        ready_mode = 2;
        send_frame(0);
        wait_samples(8);
        compare_model("stall");
        ready_mode = 0;
        @(posedge clk); #1;

        // reset in the middle of a frame
        fn = 4;
        for (int j = 0; j < 4; j++) begin
            fl[j] = 50 + j;
            fh[j] = 7 - 3 * j;
        end
        fork
            send_frame(0);
            begin
                wait_samples(3);
                #2 resetn = 1'b0;
                abort = 1;
                #1;
                check("midrst_out_valid", out_valid, 0);
                check("midrst_out_last", out_last, 0);
            end
        join
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        abort = 0;
        got_x.delete();
        got_l.delete();
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1);
        fn = 1; fl[0] = 10; fh[0] = 4;
        send_frame(0);
        wait_samples(2);
        check("post_rst_count", got_x.size(), 2);
        if (got_x.size() >= 2) begin
            check("post_rst_e0", got_x[0], 8);
            check("post_rst_o0", got_x[1], 12);
            check("post_rst_last0", got_l[0], 0);
            check("post_rst_last1", got_l[1], 1);
        end
        got_x.delete();
        got_l.delete();
        @(posedge clk); #1;

        // random frames, full-range coefficients, random gaps and stalls
        ready_mode = 1;
        for (int f = 0; f < 12; f++) begin
            fn = $urandom_range(1, 6);
            for (int j = 0; j < fn; j++) begin
                fl[j] = int'($urandom());
                fh[j] = int'($urandom());
                if (f < 4) begin
                    fl[j] = fl[j] >>> 20;
                    fh[j] = fh[j] >>> 20;
                end
            end
            model();
            send_frame(2);
            wait_samples(2 * fn);
            compare_model("rand");
            @(posedge clk); #1;
        end
        ready_mode = 0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
